// File: rtl/led_flow_if.sv
// led_flow_if: pattern control inputs and LED/step outputs of led_flow_ctrl; bright exists only with LED_DIM_EN
interface led_flow_if #(parameter int LED_NUM = 8);
  logic [1:0] mode;
  logic [1:0] speed;
  logic pause;
  logic [LED_NUM-1:0] led;
  logic step;
`ifdef LED_DIM_EN
  logic [3:0] bright;
  modport master(output mode, speed, pause, bright, input led, step);
  modport slave(input mode, speed, pause, bright, output led, step);
`else
  modport master(output mode, speed, pause, input led, step);
  modport slave(input mode, speed, pause, output led, step);
`endif
endinterface

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: LED pattern sequencer (rotate left/right, ping-pong, fill/clear bar) with speed and pause.
// Define LED_DIM_EN to add the 4-bit bright input and PWM dimming of the LED outputs.
module led_flow_ctrl #(
  parameter int LED_NUM = 8,
  parameter int STEP_CYCLES = 25_000_000
) (
  input logic clk,
  input logic rstn,
  led_flow_if.slave bus
);
  localparam int W = $clog2(STEP_CYCLES);
  typedef enum logic [1:0] {UP, DN, FILL, CLEAR} state_t;
  state_t state, state_nxt;
  logic [LED_NUM-1:0] pattern, pattern_nxt;
  logic [W-1:0] cnt, limit;
  logic [1:0] mode_q;
  logic mode_chg, wrap, adv, step_q;
  logic pp_down, fc_clr, fc_turn, fc_clr_nxt;
  assign limit = W'((STEP_CYCLES >> bus.speed) - 1);
  assign mode_chg = bus.mode != mode_q;
  // counts above the limit (left over from a slower speed) wrap immediately
  assign wrap = cnt >= limit;
  assign adv = wrap && !bus.pause && !mode_chg;
  assign pp_down = (state == DN) != (state == DN ? pattern[0] : pattern[LED_NUM-1]);
  assign fc_clr = state == CLEAR;
  assign fc_turn = fc_clr ? ~|pattern : &pattern;
  assign fc_clr_nxt = fc_clr != fc_turn;
  always_comb begin
    pattern_nxt = mode_q == 2'b00 ? {pattern[LED_NUM-2:0], pattern[LED_NUM-1]} :
                  mode_q == 2'b01 ? {pattern[0], pattern[LED_NUM-1:1]} :
                  mode_q == 2'b10 ? (pp_down ? pattern >> 1 : pattern << 1) :
                  (fc_clr && fc_turn) ? LED_NUM'(1) : {pattern[LED_NUM-2:0], !fc_clr_nxt};
    state_nxt = mode_q == 2'b10 ? (pp_down ? DN : UP) :
                mode_q == 2'b11 ? (fc_clr_nxt ? CLEAR : FILL) : state;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pattern <= LED_NUM'(1);
      cnt <= '0;
      step_q <= 1'b0;
      state <= UP;
      mode_q <= 2'b00;
    end else begin
      mode_q <= bus.mode;
      step_q <= adv;
      if (mode_chg) begin
        pattern <= LED_NUM'(1);
        state <= bus.mode == 2'b11 ? FILL : UP;
        cnt <= '0;
      end else if (!bus.pause) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap) begin
          pattern <= pattern_nxt;
          state <= state_nxt;
        end
      end
    end
  end
  assign bus.step = step_q;
`ifdef LED_DIM_EN
  logic [3:0] pwm_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 1'b1;
  end
  assign bus.led = pwm_cnt <= bus.bright ? pattern : '0;
`else
  assign bus.led = pattern;
`endif
endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: directed and random checks of led_flow_ctrl against a sequence-index reference model
module tb_led_flow_ctrl;
  localparam int N = 4;
  localparam int SC = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  led_flow_if #(.LED_NUM(N)) bus();
  led_flow_ctrl #(.LED_NUM(N), .STEP_CYCLES(SC)) dut(.clk(clk), .rstn(rstn), .bus(bus));
  int errors = 0;
  int checks = 0;
  int m_idx = 0;
  int m_cnt = 0;
  int m_pwm = 0;
  logic [1:0] m_mode = 2'b00;
  logic m_step = 1'b0;
  logic [N-1:0] rot_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] pp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [N-1:0] fc_seq [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
  logic [N-1:0] spd_seq [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
  // every pattern is a position in a cyclic sequence per mode
  function automatic logic [N-1:0] pat(input logic [1:0] md, input int i);
    logic [N-1:0] all;
    all = '1;
    case (md)
      2'b10: return N'(1) << (i < N ? i : 2 * N - 2 - i);
      2'b11: return i < N ? N'((1 << (i + 1)) - 1) : all << (i - N + 1);
      default: return N'(1) << i;
    endcase
  endfunction
  function automatic int seq_len(input logic [1:0] md);
    return md == 2'b10 ? 2 * N - 2 : md == 2'b11 ? 2 * N : N;
  endfunction
  function automatic logic [N-1:0] gate(input logic [N-1:0] p);
`ifdef LED_DIM_EN
    return m_pwm <= int'(bus.bright) ? p : '0;
`else
    return p;
`endif
  endfunction
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_idx = 0;
      m_cnt = 0;
      m_mode = 2'b00;
      m_step = 1'b0;
      m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 16;
      m_step = 1'b0;
      if (bus.mode != m_mode) begin
        m_idx = 0;
        m_cnt = 0;
      end else if (!bus.pause) begin
        if (m_cnt >= (SC >> bus.speed) - 1) begin
          m_cnt = 0;
          m_step = 1'b1;
          m_idx = (m_idx + (m_mode == 2'b01 ? seq_len(m_mode) - 1 : 1)) % seq_len(m_mode);
        end else m_cnt++;
      end
      m_mode = bus.mode;
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (checks > 0) begin
      chk("model_led", 32'(bus.led), 32'(gate(pat(m_mode, m_idx))));
      chk("model_step", 32'(bus.step), 32'(m_step));
    end
  end
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.step && n < 40);
    chk("step_seen", 32'(bus.step), 32'd1);
  endtask
  initial begin
    int n;
    int lit;
    bus.mode = 2'b00;
    bus.speed = 2'b00;
    bus.pause = 1'b0;
`ifdef LED_DIM_EN
    bus.bright = 4'd3;
`endif
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(bus.led), 32'd1);
    chk("rst_step", 32'(bus.step), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_step(n);
      chk("rot_period", n, 8);
      chk("rot_led", 32'(bus.led), 32'(gate(rot_seq[i])));
    end
    bus.mode = 2'b10;
    @(negedge clk);
    chk("pp_load", 32'(bus.led), 32'(gate(4'b0001)));
    for (int i = 0; i < 7; i++) begin
      wait_step(n);
      chk("pp_led", 32'(bus.led), 32'(gate(pp_seq[i])));
    end
    bus.mode = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wait_step(n);
      chk("fc_led", 32'(bus.led), 32'(gate(fc_seq[i])));
    end
    bus.mode = 2'b00;
    @(negedge clk);
    wait_step(n);
    wait_step(n);
    chk("rot_0100", 32'(bus.led), 32'(gate(4'b0100)));
    bus.mode = 2'b01;
    @(negedge clk);
    chk("chg_led", 32'(bus.led), 32'(gate(4'b0001)));
    wait_step(n);
    chk("chg_period", n, 8);
    chk("chg_led2", 32'(bus.led), 32'(gate(4'b1000)));
    repeat (6) @(negedge clk);
    bus.speed = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spd_step", 32'(bus.step), 32'd1);
      chk("spd_led", 32'(bus.led), 32'(gate(spd_seq[i])));
    end
    bus.pause = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("pause_step", 32'(bus.step), 32'd0);
      chk("pause_led", 32'(bus.led), 32'(gate(4'b1000)));
    end
`ifdef LED_DIM_EN
    lit = 0;
    repeat (16) begin
      @(negedge clk);
      lit += bus.led != '0 ? 1 : 0;
    end
    chk("dim_duty", lit, 4);
`endif
    bus.pause = 1'b0;
    bus.speed = 2'b00;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_led", 32'(bus.led), 32'd1);
    chk("arst_step", 32'(bus.step), 32'd0);
    bus.mode = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    wait_step(n);
    chk("arst_period", n, 8);
    chk("arst_next", 32'(bus.led), 32'(gate(4'b0010)));
    repeat (600) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 15) == 0) bus.speed = 2'($urandom);
      bus.pause = $urandom_range(0, 7) == 0;
`ifdef LED_DIM_EN
      if ($urandom_range(0, 31) == 0) bus.bright = 4'($urandom);
`endif
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_flow_ctrl.md
LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 The block SHALL provide parameter LED_NUM, default 8, number of LED outputs (legal range 2..32).
REQ-002 The block SHALL provide parameter STEP_CYCLES, default 25_000_000, clock cycles per pattern step at speed 0 (legal minimum 8).
REQ-003 Port clk, input, 1 bit: sole clock; reset is asynchronous and active-low.
REQ-004 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 Port mode, input, 2 bits: pattern select; 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill/clear bar.
REQ-006 Port speed, input, 2 bits: step period = STEP_CYCLES >> speed.
REQ-007 Port pause, input, 1 bit: high freezes the step counter and pattern.
REQ-008 Port led, output, LED_NUM bits: LED drive, 1 = on.
REQ-009 Port step, output, 1 bit: one-cycle pulse on each cycle where the pattern advances.

Function
REQ-010 Step counter SHALL be $clog2(STEP_CYCLES) bits wide, count 0..LIMIT with LIMIT = (STEP_CYCLES >> speed) - 1, and wrap to 0 after LIMIT.
REQ-011 Counter value >= LIMIT (after a speed decrease) SHALL be treated as terminal: wrap to 0 on the next cycle and generate a step.
REQ-012 Step SHALL be asserted on the cycle where the counter wraps and pause is low; pattern register updates on that same edge.
REQ-013 Pause high SHALL hold counter, pattern and direction/phase state; step stays 0; resume continues from the held count.
REQ-014 Mode 00: on step, pattern rotates one bit toward MSB (MSB wraps to bit 0).
REQ-015 Mode 01: on step, pattern rotates one bit toward LSB (bit 0 wraps to MSB).
REQ-016 Mode 10: single lit LED with FSM states UP/DN; UP shifts toward MSB; a step taken with pattern at bit LED_NUM-1 moves to bit LED_NUM-2 and enters DN; DN mirrors this at bit 0, moving to bit 1 and entering UP; no dwell at the ends.
REQ-017 Mode 11: FSM states FILL/CLEAR; FILL step: pattern = {pattern[LED_NUM-2:0],1}; FILL with all ones: step shifts in 0 and enters CLEAR; CLEAR step: pattern = {pattern[LED_NUM-2:0],0}; CLEAR with all zeros: step sets pattern to 1 and enters FILL.
REQ-018 A mode value differing from the previous cycle's registered mode SHALL, on the next edge, load pattern 1 (bit 0 lit), state UP/FILL and counter 0, with no step that cycle; this takes priority over pause.
REQ-019 Mode 00/01/10 patterns SHALL always remain one-hot.

Reset
REQ-020 rstn low SHALL asynchronously set pattern to 1 (led = 1), counter to 0, step to 0, FSM to UP/FILL, and registered mode to 00.
REQ-021 Reset asserted mid-step SHALL discard the partial count; after release the first step occurs LIMIT+1 cycles later.

Configuration
REQ-022 Macro LED_DIM_EN SHALL enable brightness dimming: it adds input port bright (4 bits), a free-running 4-bit PWM counter reset to 0, and led = pattern gated on while pwm_cnt <= bright, giving a (bright+1)/16 duty cycle (15 = always on).
REQ-023 Without LED_DIM_EN, port bright and the PWM counter SHALL NOT exist, and led SHALL equal the pattern register directly.

Verification (LED_NUM=4, STEP_CYCLES=8)
REQ-024 Mode 00, speed 0, release reset -> step every 8 cycles; led sequence 0001,0010,0100,1000,0001.
REQ-025 Mode 10 -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010; no repeated value at the ends.
REQ-026 Mode 11 -> led sequence 0001,0011,0111,1111,1110,1100,1000,0000,0001.
REQ-027 Speed 0 -> 3 at count 6 -> wrap and step on the next cycle, then step every 1 cycle; pause held 20 cycles -> led and counter frozen, step 0.
REQ-028 Mode 00 -> 01 change at led 0100 -> led 0001 and counter 0 on the next edge; the next step, 8 cycles later, gives 1000.
REQ-029 With LED_DIM_EN and bright=3 -> each lit LED high 4 of every 16 cycles; rstn pulsed low mid-step -> led 0001 immediately, asynchronously.
